cra_diag_master: RTL

Front-end-side EBUS diagnostic initiator for the CRAM address sequencer. It issues the diagnostic write functions that load the 11-bit diagnostic CRAM address (functions 051 and 052). It also issues the 14X diagnostic read functions that return CRADR, the subroutine-return register, and stack or dispatch status. Each request is split into two EBUS transactions, sequenced with strobe and settle timing, and the two returned halves are assembled into one response word.

---
 rtl/cra_diag_pkg.sv | 62 ++++++
 rtl/cra_diag_master_timer.sv | 41 ++++
 rtl/cra_diag_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cra_diag_pkg.sv
// -----------------------------------------------------------------------------
// cra_diag_pkg
// Shared definitions for the CRAM-address diagnostic initiator:
//   - tCraDiagOp     : request opcode (LOAD_ADR / READ_CRADR / READ_SBR / READ_STATUS)
//   - tCraDiagState  : sequencer FSM states
//   - diagnostic function codes (octal) and the timer width
//   - helpers that map (op, phase) to the EBUS function code and write data
// EBUS vectors use big-endian numbering: bit 0 is the most significant bit.
// -----------------------------------------------------------------------------
package cra_diag_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_ADR    = 2'd0,
    OP_READ_CRADR  = 2'd1,
    OP_READ_SBR    = 2'd2,
    OP_READ_STATUS = 2'd3
  } tCraDiagOp;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_DONE   = 3'd6
  } tCraDiagState;

  localparam logic [0:6] DIAG_LDAR_LO  = 7'o051;  // loads CRA address bits 5:10
  localparam logic [0:6] DIAG_LDAR_HI  = 7'o052;  // loads CRA address bits 0:4
  localparam logic [0:6] DIAG_READ_CRA = 7'o140;  // base of the 14X read group

  // Wide enough for the largest timeout count (255).
  localparam int TIMER_W = 8;

  // Phase 0 is the first EBUS transaction of a request, phase 1 the second.
  // Reads: 140/141 status, 142/143 SBR, 144/145 CRADR.
  function automatic logic [0:6] diag_func_code(input tCraDiagOp op, input logic phase);
    logic [0:6] code;
    case (op)
      OP_LOAD_ADR:   code = phase ? DIAG_LDAR_LO : DIAG_LDAR_HI;
      OP_READ_CRADR: code = DIAG_READ_CRA | 7'o004 | {6'b0, phase};
      OP_READ_SBR:   code = DIAG_READ_CRA | 7'o002 | {6'b0, phase};
      default:       code = DIAG_READ_CRA | {6'b0, phase};
    endcase
    return code;
  endfunction

  // Write data for LOAD_ADR: phase 0 puts adr[0:4] on data[1:5] (func 052),
  // phase 1 puts adr[5:10] on data[0:5] (func 051). All other bits are 0.
  function automatic logic [0:35] diag_wr_data(input logic [0:10] adr, input logic phase);
    logic [0:35] d;
    d = '0;
    if (!phase) begin
      d[1:5] = adr[0:4];
    end else begin
      d[0:5] = adr[5:10];
    end
    return d;
  endfunction

endpackage

// File: rtl/cra_diag_master_timer.sv
// -----------------------------------------------------------------------------
// diag_cycle_timer
// Loadable down-counter with a zero flag. Shared by the strobe width, the read
// settle time and (optionally) the arbitration timeout. Loading N-1 on entry to
// a timed state makes o_zero assert on that state's N-th cycle.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_load      load i_load_val (has priority over i_dec)
//   i_load_val  value to load
//   i_dec       decrement; saturates at zero
//   o_zero      count is zero
// -----------------------------------------------------------------------------
module diag_cycle_timer
  import cra_diag_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cra_diag_master.sv
// -----------------------------------------------------------------------------
// cra_diag_master
// Front-end EBUS diagnostic initiator for the CRAM address sequencer. A request
// is split into two EBUS diagnostic transactions (write 052/051 for LOAD_ADR,
// read 14X pairs otherwise) and the two halves are merged into rspData.
//
// Optional feature macro: CRA_DIAG_TIMEOUT_EN
//   defined   - ARB gives up after TIMEOUT_CYCLES without ebusGrant (rspErr=1)
//   undefined - ARB waits for ebusGrant indefinitely, no timeout counting
//
// Ports:
//   eboxClk, eboxResetN          clock, asynchronous active-low reset
//   reqValid/reqReady/reqOp/reqAdr  request handshake (accepted in IDLE only)
//   rspValid/rspData/rspErr      one-cycle response pulse, data held after
//   ebusReq/ebusGrant            EBUS ownership handshake
//   diagFunc/diagStrobe          diagnostic function code and write strobe
//   ebusDriving/ebusDataOut      EBUS data drive enable and value
//   ebusDataIn                   EBUS data sampled on reads (bits 0:5 used)
// -----------------------------------------------------------------------------
module cra_diag_master
  import cra_diag_pkg::*;
#(
  parameter int STROBE_CYCLES  = 2,
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        eboxClk,
  input  logic        eboxResetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  reqOp,
  input  logic [0:10] reqAdr,
  output logic        rspValid,
  output logic [0:11] rspData,
  output logic        rspErr,
  output logic        ebusReq,
  input  logic        ebusGrant,
  output logic [0:6]  diagFunc,
  output logic        diagStrobe,
  output logic        ebusDriving,
  output logic [0:35] ebusDataOut,
  input  logic [0:35] ebusDataIn
);

  localparam logic [TIMER_W-1:0] L_STROBE_LD = TIMER_W'(STROBE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] L_SETTLE_LD = TIMER_W'(SETTLE_CYCLES - 1);

  tCraDiagState r_state;
  tCraDiagOp    r_op;
  logic [0:10]  r_adr;
  logic         r_phase;
  logic [0:5]   r_half1;
  logic         r_reqReady;
  logic         r_rspValid;
  logic         r_rspErr;
  logic [0:11]  r_rspData;
  logic         r_ebusReq;
  logic [0:6]   r_diagFunc;
  logic         r_diagStrobe;
  logic         r_ebusDriving;
  logic [0:35]  r_ebusDataOut;

  logic               w_wr;
  logic               w_in_xfer;
  logic               w_tmr_load;
  logic [TIMER_W-1:0] w_tmr_val;
  logic               w_tmr_dec;
  logic               w_tmr_zero;
  logic               w_unused;

  assign w_wr      = (r_op == OP_LOAD_ADR);
  // States in which ownership must be kept; losing the grant here aborts.
  assign w_in_xfer = (r_state == ST_SETUP) || (r_state == ST_STROBE) ||
                     (r_state == ST_HOLD)  || (r_state == ST_SETTLE);

  // Only ebusDataIn[0:5] carries diagnostic read data.
  assign w_unused = ^ebusDataIn[6:35];

  // Timer control: loaded in the cycle before a timed state so that the zero
  // flag marks the last cycle of that state.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_dec  = 1'b0;
    case (r_state)
`ifdef CRA_DIAG_TIMEOUT_EN
      ST_IDLE: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TIMER_W'(TIMEOUT_CYCLES - 1);
      end
      ST_ARB: w_tmr_dec = 1'b1;
`endif
      ST_SETUP: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = w_wr ? L_STROBE_LD : L_SETTLE_LD;
      end
      ST_STROBE, ST_SETTLE: w_tmr_dec = 1'b1;
      default: ;
    endcase
  end

`ifndef CRA_DIAG_TIMEOUT_EN
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  diag_cycle_timer #(.W(TIMER_W)) u_timer (
    .i_clk      (eboxClk),
    .i_rst_n    (eboxResetN),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_LOAD_ADR;
      r_adr         <= '0;
      r_phase       <= 1'b0;
      r_half1       <= '0;
      r_reqReady    <= 1'b1;
      r_rspValid    <= 1'b0;
      r_rspErr      <= 1'b0;
      r_rspData     <= '0;
      r_ebusReq     <= 1'b0;
      r_diagFunc    <= '0;
      r_diagStrobe  <= 1'b0;
      r_ebusDriving <= 1'b0;
      r_ebusDataOut <= '0;
    end else begin
      r_rspValid <= 1'b0;
      if (w_in_xfer && !ebusGrant) begin
        // Grant lost: release the bus on this edge, report error, keep rspData.
        r_state       <= ST_DONE;
        r_rspValid    <= 1'b1;
        r_rspErr      <= 1'b1;
        r_ebusReq     <= 1'b0;
        r_diagFunc    <= '0;
        r_diagStrobe  <= 1'b0;
        r_ebusDriving <= 1'b0;
        r_ebusDataOut <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_rspErr <= 1'b0;
            if (reqValid) begin
              r_op       <= tCraDiagOp'(reqOp);
              r_adr      <= reqAdr;
              r_phase    <= 1'b0;
              r_reqReady <= 1'b0;
              r_ebusReq  <= 1'b1;
              r_state    <= ST_ARB;
            end
          end
          ST_ARB: begin
            if (ebusGrant) begin
              r_state       <= ST_SETUP;
              r_diagFunc    <= diag_func_code(r_op, 1'b0);
              r_ebusDriving <= w_wr;
              r_ebusDataOut <= w_wr ? diag_wr_data(r_adr, 1'b0) : '0;
            end
`ifdef CRA_DIAG_TIMEOUT_EN
            else if (w_tmr_zero) begin
              r_state    <= ST_DONE;
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_ebusReq  <= 1'b0;
            end
`endif
          end
          ST_SETUP: begin
            if (w_wr) begin
              r_state      <= ST_STROBE;
              r_diagStrobe <= 1'b1;
            end else begin
              r_state <= ST_SETTLE;
            end
          end
          ST_STROBE: begin
            if (w_tmr_zero) begin
              r_state      <= ST_HOLD;
              r_diagStrobe <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!r_phase) begin
              r_phase       <= 1'b1;
              r_state       <= ST_SETUP;
              r_diagFunc    <= diag_func_code(r_op, 1'b1);
              r_ebusDataOut <= diag_wr_data(r_adr, 1'b1);
            end else begin
              r_state       <= ST_DONE;
              r_rspValid    <= 1'b1;
              r_rspData     <= {1'b0, r_adr};
              r_ebusReq     <= 1'b0;
              r_diagFunc    <= '0;
              r_ebusDriving <= 1'b0;
              r_ebusDataOut <= '0;
            end
          end
          ST_SETTLE: begin
            if (w_tmr_zero) begin
              if (!r_phase) begin
                r_half1    <= ebusDataIn[0:5];
                r_phase    <= 1'b1;
                r_state    <= ST_SETUP;
                r_diagFunc <= diag_func_code(r_op, 1'b1);
              end else begin
                // Second read supplies the high half, first read the low half.
                r_state    <= ST_DONE;
                r_rspValid <= 1'b1;
                r_rspData  <= {ebusDataIn[0:5], r_half1};
                r_ebusReq  <= 1'b0;
                r_diagFunc <= '0;
              end
            end
          end
          ST_DONE: begin
            r_state    <= ST_IDLE;
            r_reqReady <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign reqReady    = r_reqReady;
  assign rspValid    = r_rspValid;
  assign rspData     = r_rspData;
  assign rspErr      = r_rspErr;
  assign ebusReq     = r_ebusReq;
  assign diagFunc    = r_diagFunc;
  assign diagStrobe  = r_diagStrobe;
  assign ebusDriving = r_ebusDriving;
  assign ebusDataOut = r_ebusDataOut;

endmodule
